// File: rtl/attn_value_mul.sv
// Sequential A x V for one attention head: one fixed-point MAC per cycle,
// N MAC cycles plus one store cycle per output element, row-major order.
module attn_value_mul #(
  parameter int N     = 4,
  parameter int D     = 4,
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic signed [N-1:0][N-1:0][WIDTH-1:0]    A,
  input  logic signed [N-1:0][D-1:0][WIDTH-1:0]    V,
  output logic signed [N-1:0][D-1:0][WIDTH-1:0]    Out,
  output logic                                     busy,
  output logic                                     done
);

  localparam int ACC_W = 2*WIDTH + $clog2(N);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int JW    = (D > 1) ? $clog2(D) : 1;

  // Signed WIDTH range expressed at accumulator width for the saturation compare
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

  state_t state, state_n;

  logic signed [N-1:0][N-1:0][WIDTH-1:0] a_reg;
  logic signed [N-1:0][D-1:0][WIDTH-1:0] v_reg;
  logic [IW-1:0] i, k;
  logic [JW-1:0] j;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] term;
  logic [WIDTH-1:0]          sat_val;
  logic last_i, last_j, last_k;

  assign last_i = (i == IW'(N-1));
  assign last_j = (j == JW'(D-1));
  assign last_k = (k == IW'(N-1));
  assign busy   = (state != IDLE);

  // Full-precision product, then floor shift back to the fixed-point scale
  assign prod = (2*WIDTH)'($signed(a_reg[i][k])) * (2*WIDTH)'($signed(v_reg[k][j]));
  assign term = prod >>> FBITS;

  always_comb begin
    sat_val = acc[WIDTH-1:0];
    if (acc > SAT_MAX)      sat_val = SAT_MAX[WIDTH-1:0];
    else if (acc < SAT_MIN) sat_val = SAT_MIN[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = MAC;
      MAC:     if (last_k) state_n = STORE;
      STORE:   state_n = (last_i && last_j) ? DONE : MAC;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand snapshot; no reset needed since it is always loaded before use
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_reg <= A;
      v_reg <= V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      acc  <= '0;
      Out  <= '0;
      done <= 1'b0;
    end else begin
      done <= (state == STORE) && last_i && last_j;
      case (state)
        IDLE: if (start) begin
          i   <= '0;
          j   <= '0;
          k   <= '0;
          acc <= '0;
        end
        MAC: begin
          acc <= acc + ACC_W'(term);
          if (!last_k) k <= k + IW'(1);
        end
        STORE: begin
          Out[i][j] <= sat_val;
          acc       <= '0;
          k         <= '0;
          if (last_j) begin
            j <= '0;
            if (!last_i) i <= i + IW'(1);
          end else begin
            j <= j + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_value_mul.sv
// Scoreboard bench for attn_value_mul: expected matrices are queued at start
// and compared against Out whenever done is observed.
module tb_attn_value_mul;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 32;
  localparam int FB = 8;
  localparam int MW = N*D*W;
  localparam int AW = 2*W + 8;
  localparam int LAT = N*D*(N+1);

  typedef logic [N-1:0][N-1:0][W-1:0] mat_a_t;
  typedef logic [N-1:0][D-1:0][W-1:0] mat_v_t;

  logic   clk, rst, start;
  mat_a_t A;
  mat_v_t V, Out;
  logic   busy, done;

  int     n_chk, n_err;
  mat_v_t sb[$];
  logic   done_q;

  attn_value_mul #(.N(N), .D(D), .WIDTH(W), .FBITS(FB)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .V(V),
    .Out(Out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic mat_v_t model(input mat_a_t a, input mat_v_t v);
    mat_v_t r;
    logic signed [AW-1:0]  acc, mx, mn;
    logic signed [2*W-1:0] p;
    mx = '0; mx[W-2:0] = '1;
    mn = '1; mn[W-2:0] = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < D; j++) begin
        acc = '0;
        for (int k = 0; k < N; k++) begin
          p   = (2*W)'($signed(a[i][k])) * (2*W)'($signed(v[k][j]));
          acc = acc + AW'(p >>> FB);
        end
        if (acc > mx)      r[i][j] = mx[W-1:0];
        else if (acc < mn) r[i][j] = mn[W-1:0];
        else               r[i][j] = acc[W-1:0];
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", MW'(done_q), MW'(0));
      if (sb.size() == 0) check("unexpected_done", MW'(1), MW'(0));
      else                check("out_matrix", Out, sb.pop_front());
    end
    done_q <= done;
  end

  // Called at a negedge; drives start for one edge and waits for done
  task automatic do_op(input mat_a_t a, input mat_v_t v, input bit scramble);
    int lat, busy_bad;
    A = a; V = v; start = 1'b1;
    sb.push_back(model(a, v));
    @(negedge clk);
    start = 1'b0;
    if (scramble)
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) A[r][c] = $urandom;
        for (int c = 0; c < D; c++) V[r][c] = $urandom;
      end
    lat = 0; busy_bad = 0;
    while (!done && lat < 300) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check("latency", MW'(lat), MW'(LAT));
    check("busy_during_op", MW'(busy_bad), MW'(0));
    @(negedge clk);
    check("done_fall", MW'(done), MW'(0));
    check("busy_fall", MW'(busy), MW'(0));
  endtask

  mat_a_t ta;
  mat_v_t tv;
  int     ndone, off;

  initial begin
    n_chk = 0; n_err = 0; done_q = 1'b0;
    rst = 1'b1; start = 1'b0; A = '0; V = '0;
    repeat (2) @(negedge clk);
    check("rst_out", Out, '0);
    check("rst_busy", MW'(busy), MW'(0));
    check("rst_done", MW'(done), MW'(0));
    rst = 1'b0;
    @(negedge clk);

    // identity weights reproduce V
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = (r == c) ? 32'd256 : 32'd0;
      for (int c = 0; c < D; c++) tv[r][c] = 256*r + c;
    end
    do_op(ta, tv, 0);
    check("identity_eq_v", Out, tv);

    // uniform rows, back-to-back with the previous op
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = 32'd64;
      for (int c = 0; c < D; c++) tv[r][c] = 32'd1024;
    end
    do_op(ta, tv, 0);
    check("uniform_elem", MW'(Out[2][3]), MW'(1024));

    // floor shift on negative products
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = 32'd1;
      for (int c = 0; c < D; c++) tv[r][c] = 32'hFFFF_FFFF;
    end
    do_op(ta, tv, 0);
    check("trunc_elem", MW'(Out[1][1]), MW'(32'hFFFF_FFFC));

    ta = '0; tv = '0; ta[0][0] = 32'd256; tv[0][0] = -32'sd512;
    do_op(ta, tv, 0);
    check("neg_single", MW'(Out[0][0]), MW'(32'hFFFF_FE00));

    // saturation both directions
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = 32'h7FFF_FFFF;
      for (int c = 0; c < D; c++) tv[r][c] = 32'h7FFF_FFFF;
    end
    do_op(ta, tv, 0);
    check("sat_max", MW'(Out[3][0]), MW'(32'h7FFF_FFFF));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < D; c++) tv[r][c] = 32'h8000_0000;
    do_op(ta, tv, 0);
    check("sat_min", MW'(Out[0][3]), MW'(32'h8000_0000));

    // snapshot isolation: inputs scrambled right after the start edge
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = $urandom_range(0, 512);
      for (int c = 0; c < D; c++) tv[r][c] = $urandom;
    end
    do_op(ta, tv, 1);

    // start held high: restarts only after each op completes
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = $urandom;
      for (int c = 0; c < D; c++) tv[r][c] = $urandom;
    end
    A = ta; V = tv; start = 1'b1;
    repeat (3) sb.push_back(model(ta, tv));
    ndone = 0; off = 0;
    while (ndone < 3 && off < 400) begin
      @(negedge clk);
      off++;
      if (done) ndone++;
    end
    start = 1'b0;
    check("held_start_dones", MW'(ndone), MW'(3));
    check("held_start_span", MW'(off >= 243 && off <= 245), MW'(1));
    @(negedge clk);

    // reset mid-operation aborts without a done pulse
    A = ta; V = tv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out", Out, '0);
    check("abort_busy", MW'(busy), MW'(0));
    check("abort_done", MW'(done), MW'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_still_idle", MW'(busy), MW'(0));

    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) ta[r][c] = $urandom_range(0, 300);
      for (int c = 0; c < D; c++) tv[r][c] = $urandom_range(0, 1 << 20) - (1 << 19);
    end
    do_op(ta, tv, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", MW'(sb.size()), MW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
